// File: rtl/dmem_store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_store_buffer_if
//  Description : Core-side and RAM-side signals of the posted-write store
//                buffer. slave = the buffer, master = core/RAM environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_store_buffer_if;
    // core store port (ID stage)
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_we;
    // core load port (EXE stage)
    logic [31:0] core_fetch_addr;
    logic [31:0] core_rdata;
    // core status
    logic        stall;
    logic        empty;
    // RAM asynchronous read port
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    // RAM handshaked write port
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ready;

    modport slave (
        input  core_addr, core_wdata, core_we, core_fetch_addr,
        input  mem_rdata, mem_ready,
        output core_rdata, stall, empty,
        output mem_raddr, mem_waddr, mem_wdata, mem_we
    );

    modport master (
        output core_addr, core_wdata, core_we, core_fetch_addr,
        output mem_rdata, mem_ready,
        input  core_rdata, stall, empty,
        input  mem_raddr, mem_waddr, mem_wdata, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_store_buffer
//  Description : Posted-write buffer between the core data-memory port and a
//                slow handshaked data RAM. Stores queue in a circular FIFO and
//                drain one per mem_ready handshake; loads forward from the
//                youngest matching queued store, else from the RAM read port.
//                Optional macro STORE_MERGE_EN: a store hitting a queued entry
//                (other than the head being written) overwrites it in place.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    dmem_store_buffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [29:0]        r_addr [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_merge_hit;
    logic               w_mem_we;
    logic [31:0]        w_rdata;
    logic [PTR_W-1:0]   w_fwd_idx;
    logic [1:0]         w_unused_addr_lsb;

    assign w_full  = (r_count == c_cnt_full);
    assign w_empty = (r_count == '0);

    // The head leaves on every handshake edge while the write is presented.
    assign w_pop  = (r_state == S_WRITE) && bus.mem_ready;
    // A new entry is allocated only for non-merging stores while not stalled.
    assign w_push = bus.core_we && !w_full && !w_merge_hit;

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0]   w_merge_idx;

    // Find a queued entry for the same word; the head under write is frozen.
    always_comb begin
        w_merge_hit = 1'b0;
        w_merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.core_we && r_valid[i] && (r_addr[i] == bus.core_addr[31:2]) &&
                !((PTR_W'(i) == r_rd_ptr) && (r_state == S_WRITE))) begin
                w_merge_hit = 1'b1;
                w_merge_idx = PTR_W'(i);
            end
        end
    end
`else
    assign w_merge_hit = 1'b0;
`endif

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    // Entry payload; no reset needed because valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= bus.core_addr[31:2];
            r_data[r_wr_ptr] <= bus.core_wdata;
        end
`ifdef STORE_MERGE_EN
        if (w_merge_hit) begin
            r_data[w_merge_idx] <= bus.core_wdata;
        end
`endif
    end

    // Pointers, valid bits and count; reset discards everything queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_next;
        end
    end

    // Drain FSM state register; asynchronous reset drops mem_we at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Drain FSM next state and write request.
    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_mem_we = 1'b1;
                if (w_pop && (w_count_next == '0)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Load forwarding: walk oldest to youngest so the youngest match wins.
    always_comb begin
        w_rdata   = bus.mem_rdata;
        w_fwd_idx = r_rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd_idx = r_rd_ptr + PTR_W'(k);
            if (r_valid[w_fwd_idx] && (r_addr[w_fwd_idx] == bus.core_fetch_addr[31:2])) begin
                w_rdata = r_data[w_fwd_idx];
            end
        end
    end

    // Byte offset of store addresses has no meaning for word writes.
    assign w_unused_addr_lsb = bus.core_addr[1:0];

    assign bus.core_rdata = w_rdata;
    assign bus.stall      = w_full;
    assign bus.empty      = w_empty;
    assign bus.mem_raddr  = bus.core_fetch_addr;
    assign bus.mem_waddr  = {r_addr[r_rd_ptr], 2'b00};
    assign bus.mem_wdata  = r_data[r_rd_ptr];
    assign bus.mem_we     = w_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_store_buffer
//  Description : Self-checking bench for dmem_store_buffer. A queue-based
//                model of pending stores predicts stall/empty/mem_we, the RAM
//                write sequence and load forwarding results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset;

    dmem_store_buffer_if bus ();

    dmem_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: pending stores oldest-first, and whether a write is presented.
    ent_t        mq[$];
    bit          m_busy;
    logic [63:0] exp_log[$];
    logic [63:0] dut_log[$];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [31:0] ram);
        logic [31:0] r;
        r = ram;
        foreach (mq[i]) if (mq[i].a == addr[31:2]) r = mq[i].d;
        return r;
    endfunction

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic tick();
        bit pop, push, merge;
        int mi, size_before;
        size_before = mq.size();
        pop   = m_busy && bus.mem_ready;
        merge = 1'b0;
        mi    = -1;
`ifdef STORE_MERGE_EN
        if (bus.core_we)
            foreach (mq[i])
                if (mq[i].a == bus.core_addr[31:2] && !(i == 0 && m_busy)) mi = i;
        merge = (mi >= 0);
`endif
        push = bus.core_we && !merge && (size_before < DEPTH);
        if (bus.mem_we === 1'b1 && bus.mem_ready) dut_log.push_back({bus.mem_waddr, bus.mem_wdata});
        @(posedge clk);
        #1;
        if (merge) mq[mi].d = bus.core_wdata;
        if (pop) begin
            exp_log.push_back({mq[0].a, 2'b00, mq[0].d});
            void'(mq.pop_front());
        end
        if (push) mq.push_back('{a: bus.core_addr[31:2], d: bus.core_wdata});
        m_busy = m_busy ? (mq.size() > 0) : (size_before > 0);
    endtask

    task automatic set_idle();
        bus.core_we         = 1'b0;
        bus.core_addr       = '0;
        bus.core_wdata      = '0;
        bus.core_fetch_addr = '0;
        bus.mem_rdata       = '0;
        bus.mem_ready       = 1'b0;
    endtask

    task automatic drain();
        bus.core_we   = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH + 4 && (mq.size() > 0 || m_busy); i++) tick();
        bus.mem_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        #3;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        n_checks++; if (bus.stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        @(negedge clk);
        reset = 1'b0;
        mq.delete(); m_busy = 1'b0; exp_log.delete(); dut_log.delete();
        tick();
        n_checks++; if (bus.empty !== 1'b1 || bus.mem_we !== 1'b0) begin n_errors++; $display("FAIL post_reset_idle: got empty=%b we=%b want 1 0", bus.empty, bus.mem_we); end
    endtask

    task automatic test_single_store();
        bus.mem_ready = 1'b0;
        bus.core_we = 1'b1; bus.core_addr = 32'h100; bus.core_wdata = 32'hA5A5A5A5;
        tick();
        bus.core_we = 1'b0;
        #1;
        n_checks++; if (bus.empty !== 1'b0) begin n_errors++; $display("FAIL single_queued: got empty=%b want 0", bus.empty); end
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 32'h100 || bus.mem_wdata !== 32'hA5A5A5A5) begin
                n_errors++; $display("FAIL single_hold%0d: got we=%b %h/%h want 1 00000100/a5a5a5a5", i, bus.mem_we, bus.mem_waddr, bus.mem_wdata);
            end
            if (i < 2) tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        n_checks++; if (bus.empty !== 1'b1 || bus.mem_we !== 1'b0) begin n_errors++; $display("FAIL single_done: got empty=%b we=%b want 1 0", bus.empty, bus.mem_we); end
        n_checks++; if (dut_log.size() != 1 || dut_log[0] !== {32'h100, 32'hA5A5A5A5}) begin n_errors++; $display("FAIL single_ram: got %0d writes want 1 of 00000100/a5a5a5a5", dut_log.size()); end
        dut_log.delete(); exp_log.delete();
    endtask

    task automatic test_full_stall();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.core_we = 1'b1; bus.core_addr = 32'(4 * i); bus.core_wdata = $urandom;
            #1;
            n_checks++; if (bus.stall !== 1'b0) begin n_errors++; $display("FAIL full_pre_stall%0d: got %b want 0", i, bus.stall); end
            tick();
        end
        bus.core_addr = 32'h10; bus.core_wdata = 32'h10101010;
        #1;
        n_checks++; if (bus.stall !== 1'b1) begin n_errors++; $display("FAIL full_stall: got %b want 1", bus.stall); end
        tick();
        n_checks++; if (bus.stall !== 1'b1) begin n_errors++; $display("FAIL full_reject: got stall=%b want 1", bus.stall); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        n_checks++; if (bus.stall !== (mq.size() == DEPTH)) begin n_errors++; $display("FAIL full_freed: got stall=%b want %b", bus.stall, mq.size() == DEPTH); end
        n_checks++; if (dut_log.size() != 1 || dut_log[0][63:32] !== 32'h0) begin n_errors++; $display("FAIL full_first_write: got %0d writes want 1 to 00000000", dut_log.size()); end
        tick();
        bus.core_we = 1'b0;
        #1;
        n_checks++; if (bus.stall !== 1'b1) begin n_errors++; $display("FAIL full_accept5: got stall=%b want 1", bus.stall); end
        drain();
        n_checks++; if (dut_log.size() != exp_log.size()) begin n_errors++; $display("FAIL full_log_len: got %0d want %0d", dut_log.size(), exp_log.size()); end
        for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++) begin
            n_checks++; if (dut_log[i] !== exp_log[i]) begin n_errors++; $display("FAIL full_log%0d: got %h want %h", i, dut_log[i], exp_log[i]); end
        end
        dut_log.delete(); exp_log.delete();
    endtask

    task automatic test_forward_same_addr();
        int exp_writes;
        bus.mem_ready = 1'b0;
        bus.core_we = 1'b1; bus.core_addr = 32'h200; bus.core_wdata = 32'h11111111;
        tick();
        bus.core_wdata = 32'h22222222;
        tick();
        bus.core_we = 1'b0; bus.core_fetch_addr = 32'h200; bus.mem_rdata = $urandom;
        #1;
        n_checks++; if (bus.core_rdata !== 32'h22222222) begin n_errors++; $display("FAIL fwd_newest: got %h want 22222222", bus.core_rdata); end
`ifdef STORE_MERGE_EN
        exp_writes = 1;
`else
        exp_writes = 2;
`endif
        drain();
        n_checks++; if (dut_log.size() != exp_writes) begin n_errors++; $display("FAIL fwd_write_count: got %0d want %0d", dut_log.size(), exp_writes); end
        for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++) begin
            n_checks++; if (dut_log[i] !== exp_log[i]) begin n_errors++; $display("FAIL fwd_log%0d: got %h want %h", i, dut_log[i], exp_log[i]); end
        end
        n_checks++; if (dut_log.size() == 0 || dut_log[dut_log.size()-1] !== {32'h200, 32'h22222222}) begin n_errors++; $display("FAIL fwd_last_write: last write not 00000200/22222222"); end
        dut_log.delete(); exp_log.delete();
    endtask

    task automatic test_load_path();
        logic [31:0] d;
        bus.core_fetch_addr = 32'h300; bus.mem_rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (bus.core_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL load_miss: got %h want deadbeef", bus.core_rdata); end
        n_checks++; if (bus.mem_raddr !== 32'h300) begin n_errors++; $display("FAIL load_raddr: got %h want 00000300", bus.mem_raddr); end
        d = $urandom;
        bus.core_we = 1'b1; bus.core_addr = 32'h300; bus.core_wdata = d;
        #1;
        n_checks++; if (bus.core_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL load_no_same_cycle_fwd: got %h want deadbeef", bus.core_rdata); end
        tick();
        bus.core_we = 1'b0; bus.core_fetch_addr = 32'h302;
        #1;
        n_checks++; if (bus.core_rdata !== d) begin n_errors++; $display("FAIL load_fwd_offset: got %h want %h", bus.core_rdata, d); end
        tick();
        bus.mem_ready = 1'b1; bus.core_fetch_addr = 32'h300;
        #1;
        n_checks++; if (bus.core_rdata !== d) begin n_errors++; $display("FAIL load_fwd_popping: got %h want %h", bus.core_rdata, d); end
        tick();
        bus.mem_ready = 1'b0;
        #1;
        n_checks++; if (bus.core_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL load_after_drain: got %h want deadbeef", bus.core_rdata); end
        dut_log.delete(); exp_log.delete();
    endtask

    task automatic test_back_to_back();
        int stalls;
        stalls = 0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.core_we = 1'b1; bus.core_addr = 32'h1000 + 32'(4 * i); bus.core_wdata = $urandom;
            #1;
            if (bus.stall !== 1'b0) stalls++;
            tick();
        end
        bus.core_we = 1'b0;
        #1;
        n_checks++; if (stalls != 0) begin n_errors++; $display("FAIL b2b_stall: got %0d stalled cycles want 0", stalls); end
        n_checks++; if (dut_log.size() != exp_log.size()) begin n_errors++; $display("FAIL b2b_rate: got %0d writes want %0d", dut_log.size(), exp_log.size()); end
        drain();
        n_checks++; if (dut_log.size() != 8) begin n_errors++; $display("FAIL b2b_count: got %0d want 8", dut_log.size()); end
        for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++) begin
            n_checks++; if (dut_log[i] !== exp_log[i]) begin n_errors++; $display("FAIL b2b_log%0d: got %h want %h", i, dut_log[i], exp_log[i]); end
        end
        dut_log.delete(); exp_log.delete();
    endtask

    task automatic test_reset_mid_drain();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.core_we = 1'b1; bus.core_addr = 32'h4000 + 32'(4 * i); bus.core_wdata = $urandom;
            tick();
        end
        bus.core_we = 1'b0;
        #1;
        n_checks++; if (bus.mem_we !== 1'b1) begin n_errors++; $display("FAIL rst_mid_busy: got we=%b want 1", bus.mem_we); end
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.mem_we !== 1'b0 || bus.empty !== 1'b1) begin n_errors++; $display("FAIL rst_mid_async: got we=%b empty=%b want 0 1", bus.mem_we, bus.empty); end
        mq.delete(); m_busy = 1'b0; exp_log.delete(); dut_log.delete();
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.mem_ready = 1'b0;
        n_checks++; if (dut_log.size() != 0 || bus.mem_we !== 1'b0 || bus.empty !== 1'b1) begin n_errors++; $display("FAIL rst_mid_after: got writes=%0d we=%b empty=%b want 0 0 1", dut_log.size(), bus.mem_we, bus.empty); end
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        int bad;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            bus.core_we         = 1'($urandom_range(0, 1));
            bus.core_addr       = 32'h2000 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            bus.core_wdata      = $urandom;
            bus.mem_ready       = ($urandom_range(0, 2) == 0);
            bus.core_fetch_addr = 32'h2000 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
            bus.mem_rdata       = $urandom;
            #1;
            exp_rd = model_load(bus.core_fetch_addr, bus.mem_rdata);
            n_checks++; if (bus.core_rdata !== exp_rd) begin n_errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, bus.core_rdata, exp_rd); end
            n_checks++; if (bus.stall !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0)) begin n_errors++; $display("FAIL rnd_status c%0d: got stall=%b empty=%b want %b %b", c, bus.stall, bus.empty, mq.size() == DEPTH, mq.size() == 0); end
            n_checks++; if (bus.mem_we !== m_busy) begin n_errors++; $display("FAIL rnd_mem_we c%0d: got %b want %b", c, bus.mem_we, m_busy); end
            if (m_busy) begin
                n_checks++;
                if (bus.mem_waddr !== {mq[0].a, 2'b00} || bus.mem_wdata !== mq[0].d) begin
                    n_errors++; $display("FAIL rnd_head c%0d: got %h/%h want %h/%h", c, bus.mem_waddr, bus.mem_wdata, {mq[0].a, 2'b00}, mq[0].d);
                end
            end
            if (n_errors > 20) bad = 1;
            tick();
            if (bad != 0) break;
        end
        drain();
        n_checks++; if (dut_log.size() != exp_log.size()) begin n_errors++; $display("FAIL rnd_log_len: got %0d want %0d", dut_log.size(), exp_log.size()); end
        for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++) begin
            n_checks++; if (dut_log[i] !== exp_log[i]) begin n_errors++; $display("FAIL rnd_log%0d: got %h want %h", i, dut_log[i], exp_log[i]); end
        end
        dut_log.delete(); exp_log.delete();
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_full_stall();
        test_forward_same_addr();
        test_load_path();
        test_back_to_back();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
Posted-write buffer between the core's data-memory port and a data RAM whose writes are slow and handshaked.
- Stores issued by the core are queued in a FIFO and drained to memory one per handshake.
- Loads are served from the newest matching queued store, otherwise from the RAM's asynchronous read port.
- Drives the core's stall when the queue is full.

Parameters:
DEPTH, 4, number of store entries; power of two, at least 2.
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
core_addr  input  32  store address from the core's ID stage (DMEM_addr)
core_wdata  input  32  store data (DMEM_wdata)
core_we  input  1  store request (DMEM_we)
core_fetch_addr  input  32  load address from the core's EXE stage (fetch_DMEM_addr)
core_rdata  output  32  load data returned to the core (DMEM_rdata)
stall  output  1  high when the queue is full; the core deasserts cpu_ena
empty  output  1  high when no stores are pending
mem_raddr  output  32  RAM asynchronous read address
mem_rdata  input  32  RAM asynchronous read data
mem_waddr  output  32  RAM write address (queue head)
mem_wdata  output  32  RAM write data (queue head)
mem_we  output  1  RAM write request
mem_ready  input  1  RAM accepts the write on this rising edge when mem_we is high

Behaviour:
- Clock/reset: one clock domain, clk. reset is asynchronous and active-high.
- Reset values: all pointers, count and valid bits 0; FSM in S_IDLE; mem_we=0; stall=0; empty=1. Entry data is don't-care.
- Reset mid-drain: queued stores are discarded and mem_we drops immediately (asynchronously).
- Storage: circular FIFO of DEPTH entries {addr[31:2], data[31:0]}, with wr_ptr, rd_ptr and count.
  - Pointers wrap modulo DEPTH.
  - Addresses are word-granular; addr[1:0] is ignored and mem_waddr[1:0]=2'b00.
- Push: on a rising edge with core_we=1 and count<DEPTH, write core_addr/core_wdata at wr_ptr and advance wr_ptr.
  - core_we while count==DEPTH is not accepted; the core is stalled and re-presents the store.
- stall = (count==DEPTH), combinational from registered count. A same-cycle pop does not clear stall early.
- empty = (count==0).
- Drain FSM:
  - S_IDLE: mem_we=0. Go to S_WRITE on the next edge when count!=0 (including the edge after the first push). Minimum push-to-mem_we latency is 1 cycle.
  - S_WRITE: mem_we=1; mem_waddr/mem_wdata show the head entry and are held stable until mem_ready.
  - On an edge with mem_ready=1: pop (advance rd_ptr). Stay in S_WRITE if the post-edge count>0, otherwise return to S_IDLE.
  - Back-to-back drains sustain 1 store per cycle when mem_ready is held high.
- Simultaneous push and pop: count unchanged. This is also legal at count==DEPTH: the pop frees a slot, but the push is rejected that cycle because stall was high.
- Load path: mem_raddr = core_fetch_addr. core_rdata is combinational, same cycle.
  - Compare core_fetch_addr[31:2] against all valid entries.
  - If one or more match, return data of the youngest match (closest to wr_ptr); otherwise return mem_rdata.
  - The head entry still forwards during the cycle it is being accepted by mem_ready.
  - A store being pushed in the same cycle is not forwarded; the load in EXE is older than that store.
- Ordering: stores reach the RAM strictly in issue order; no reordering or dropping.

Optional Feature:
Macro STORE_MERGE_EN.
- Defined: a push whose addr[31:2] matches a valid entry that is not the head in S_WRITE overwrites that entry's data in place. No allocation occurs and count is unchanged.
  - Merging is allowed even when count==DEPTH, and stall is ignored for a merge-hit store.
  - Forwarding still returns the newest data.
- Undefined: every accepted store allocates a new entry; no comparison on the push path.

Test Plan:
- Reset with mem_ready=0, then store 0x100<-0xA5A5A5A5 -> entry queued; next cycle mem_we=1, mem_waddr=0x100, mem_wdata=0xA5A5A5A5, held until mem_ready=1; then empty=1 and FSM in S_IDLE.
- mem_ready=0, issue 4 stores to 0x0,0x4,0x8,0xC -> stall=1 after the 4th; 5th store to 0x10 is not accepted. Pulse mem_ready for one edge -> 0x0 written, stall=0, 0x10 accepted next edge.
- Two stores to 0x200 (0x11111111 then 0x22222222), load 0x200 while both are queued -> core_rdata=0x22222222. With STORE_MERGE_EN: count=1 and RAM sees a single write of 0x22222222. Without it: two RAM writes in order.
- Load 0x300 with no matching entry, mem_rdata=0xDEADBEEF -> core_rdata=0xDEADBEEF; load 0x302 with entry 0x300 queued -> forwarded entry data (byte offset ignored).
- mem_ready held high, stream 8 stores on consecutive cycles -> RAM receives all 8 in order, one per cycle after 1-cycle latency, and stall never asserts.
- Assert reset while in S_WRITE with 3 entries queued -> mem_we=0 immediately, empty=1, and no further RAM writes after release.
